// File: rtl/padded_window_addr_gen.sv
// Raster-scan tap address generator over a runtime zero-padded frame.
// Emits KSIZE vertical taps per padded column per window row; pad taps are flagged.
module padded_window_addr_gen #(
  parameter int IMG_W   = 64,
  parameter int IMG_H   = 64,
  parameter int KSIZE   = 3,
  parameter int PAD_W   = 4,
  parameter int COORD_W = 8,
  parameter int ADDR_W  = 13
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [PAD_W-1:0]  pad_x,
  input  logic [PAD_W-1:0]  pad_y,
  output logic              busy,
  output logic              done,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [ADDR_W-1:0] m_addr,
  output logic              m_pad,
  output logic [2:0]        m_tap,
  output logic              m_col_last,
  output logic              m_last
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              pad;
    logic [2:0]        tap;
    logic              col_last;
    logic              last;
  } beat_t;

  // Geometry is evaluated in 32-bit ints so pad/range tests never wrap.
  function automatic beat_t calc_beat(input logic [COORD_W-1:0] px,
                                      input logic [COORD_W-1:0] py,
                                      input logic [2:0]         t,
                                      input logic [PAD_W-1:0]   pxl,
                                      input logic [PAD_W-1:0]   pyl);
    beat_t b;
    int x, r, ox, oy, pw, ph;
    x  = int'(px);
    r  = int'(py) + int'(t);
    ox = int'(pxl);
    oy = int'(pyl);
    pw = IMG_W + 2 * ox;
    ph = IMG_H + 2 * oy;
    b.pad      = (x < ox) || (x >= ox + IMG_W) || (r < oy) || (r >= oy + IMG_H);
    b.addr     = b.pad ? '0 : ADDR_W'((r - oy) * IMG_W + (x - ox));
    b.tap      = t;
    b.col_last = (int'(t) == KSIZE - 1);
    b.last     = (x == pw - 1) && (int'(py) == ph - KSIZE) && b.col_last;
    return b;
  endfunction

  state_t             state_q, state_d;
  logic [COORD_W-1:0] px_q, px_d, py_q, py_d, px_nx, py_nx;
  logic [2:0]         t_q, t_d, t_nx;
  logic [PAD_W-1:0]   padx_q, padx_d, pady_q, pady_d;
  logic               vld_q, vld_d;
  beat_t              beat_q, beat_d;

  always_comb begin
    t_nx  = t_q + 3'd1;
    px_nx = px_q;
    py_nx = py_q;
    if (int'(t_q) == KSIZE - 1) begin
      t_nx = '0;
      if (int'(px_q) == IMG_W + 2 * int'(padx_q) - 1) begin
        px_nx = '0;
        py_nx = py_q + COORD_W'(1);
      end else begin
        px_nx = px_q + COORD_W'(1);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    px_d    = px_q;
    py_d    = py_q;
    t_d     = t_q;
    padx_d  = padx_q;
    pady_d  = pady_q;
    vld_d   = vld_q;
    beat_d  = beat_q;
    case (state_q)
      IDLE: if (start) begin
        padx_d  = pad_x;
        pady_d  = pad_y;
        px_d    = '0;
        py_d    = '0;
        t_d     = '0;
        vld_d   = 1'b1;
        beat_d  = calc_beat('0, '0, '0, pad_x, pad_y);
        state_d = RUN;
      end
      RUN: if (vld_q && m_ready) begin
        if (beat_q.last) begin
          vld_d   = 1'b0;
          state_d = DONE;
        end else begin
          px_d   = px_nx;
          py_d   = py_nx;
          t_d    = t_nx;
          beat_d = calc_beat(px_nx, py_nx, t_nx, padx_q, pady_q);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      px_q    <= '0;
      py_q    <= '0;
      t_q     <= '0;
      padx_q  <= '0;
      pady_q  <= '0;
      vld_q   <= 1'b0;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      px_q    <= px_d;
      py_q    <= py_d;
      t_q     <= t_d;
      padx_q  <= padx_d;
      pady_q  <= pady_d;
      vld_q   <= vld_d;
      beat_q  <= beat_d;
    end
  end

  assign busy       = (state_q == RUN);
  assign done       = (state_q == DONE);
  assign m_valid    = vld_q;
  assign m_addr     = beat_q.addr;
  assign m_pad      = beat_q.pad;
  assign m_tap      = beat_q.tap;
  assign m_col_last = beat_q.col_last;
  assign m_last     = beat_q.last;

endmodule
